adc_spi_responder: RTL and testbench

//  Synthesizable slave-side model of the 12-bit, 8-channel SPI ADC (LTC2308 protocol) on our board.

---
 rtl/adc_spi_responder_if.sv | 22 ++
 rtl/adc_spi_responder.sv | 141 ++++++++++++++
 tb/tb_adc_spi_responder.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_responder_if.sv
// SPI-style link between the ADC reader master and the responder.
// convst/sck/sdi come from the master; sdo returns the result.
interface adc_spi_responder_if;
  logic convst;
  logic sck;
  logic sdi;
  logic sdo;

  modport master (
    output convst,
    output sck,
    output sdi,
    input  sdo
  );

  modport slave (
    input  convst,
    input  sck,
    input  sdi,
    output sdo
  );
endinterface

// File: rtl/adc_spi_responder.sv
// Slave-side model of a 12-bit 8-channel SPI ADC (LTC2308 protocol).
// Channel values come from fabric inputs; results shift out on sdo.
module adc_spi_responder #(
  parameter int         DW      = 12,
  parameter int         NCH     = 8,
  parameter int         TCONV   = 80,
  parameter logic [5:0] CFG_RST = 6'b100010
) (
  input  logic              clk,
  input  logic              rst,
  adc_spi_responder_if.slave spi,
  input  logic [NCH*DW-1:0] ch_data,
  output logic              busy,
  output logic [5:0]        cfg_word,
  output logic              frame_done
);

  localparam int CW = $clog2(TCONV);
  localparam int FW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    READY,
    SHIFT
  } state_t;

  state_t state, state_n;

  logic [2:0]    cv_q, sk_q;
  logic [1:0]    sd_q;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] sr, sr_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [2:0]    ccnt, ccnt_n;
  logic [4:0]    cfg_sr, cfg_sr_n;
  logic [5:0]    next_cfg, next_cfg_n;
  logic [5:0]    cfg_word_n;
  logic          done_n;

  logic          conv_rise, sck_rise, sck_fall, sdi_s;
  logic          start;
  logic [2:0]    ch_sel;
  logic [DW-1:0] sample;

  assign conv_rise = cv_q[1] & ~cv_q[2];
  assign sck_rise  = sk_q[1] & ~sk_q[2];
  assign sck_fall  = ~sk_q[1] & sk_q[2];
  assign sdi_s     = sd_q[1];

  // Channel index is {S1,S0,O/S}; sleep returns zero.
  assign ch_sel = {next_cfg[3], next_cfg[2], next_cfg[4]};
  assign sample = next_cfg[0] ? '0 : ch_data[int'(ch_sel)*DW +: DW];

  assign start   = conv_rise && (state != CONV);
  assign busy    = (state == CONV);
  assign spi.sdo = ((state == READY) || (state == SHIFT)) & sr[DW-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cv_q       <= '0;
      sk_q       <= '0;
      sd_q       <= '0;
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      fcnt       <= '0;
      ccnt       <= '0;
      cfg_sr     <= '0;
      next_cfg   <= CFG_RST;
      cfg_word   <= CFG_RST;
      frame_done <= 1'b0;
    end else begin
      cv_q       <= {cv_q[1:0], spi.convst};
      sk_q       <= {sk_q[1:0], spi.sck};
      sd_q       <= {sd_q[0], spi.sdi};
      state      <= state_n;
      cnt        <= cnt_n;
      sr         <= sr_n;
      fcnt       <= fcnt_n;
      ccnt       <= ccnt_n;
      cfg_sr     <= cfg_sr_n;
      next_cfg   <= next_cfg_n;
      cfg_word   <= cfg_word_n;
      frame_done <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sr_n       = sr;
    fcnt_n     = fcnt;
    ccnt_n     = ccnt;
    cfg_sr_n   = cfg_sr;
    next_cfg_n = next_cfg;
    cfg_word_n = cfg_word;
    done_n     = 1'b0;
    if (start) begin
      // A start wins over any sck edge in the same clk.
      state_n    = CONV;
      cfg_word_n = next_cfg;
      sr_n       = sample;
      cnt_n      = CW'(TCONV - 1);
      fcnt_n     = '0;
      ccnt_n     = '0;
    end else begin
      unique case (state)
        IDLE: state_n = IDLE;
        CONV: begin
          if (cnt == '0) begin
            state_n = READY;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        READY, SHIFT: begin
          if (sck_rise && (ccnt != 3'd6)) begin
            cfg_sr_n = {cfg_sr[3:0], sdi_s};
            ccnt_n   = ccnt + 1'b1;
            if (ccnt == 3'd5) begin
              next_cfg_n = {cfg_sr, sdi_s};
            end
          end
          if (sck_fall) begin
            if (fcnt == FW'(DW - 1)) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = SHIFT;
              sr_n    = {sr[DW-2:0], 1'b0};
              fcnt_n  = fcnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: timeline model of expected outputs
// checked every clk, plus literal checks on returned words.
module tb_adc_spi_responder;

  localparam int         DW      = 12;
  localparam int         NCH     = 8;
  localparam int         TCONV   = 80;
  localparam int         MAXC    = 8192;
  localparam logic [5:0] CFG_RST = 6'b100010;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DW-1:0]     ch [NCH];
  logic [NCH*DW-1:0] ch_data;
  logic              busy;
  logic [5:0]        cfg_word;
  logic              frame_done;

  adc_spi_responder_if spi();

  adc_spi_responder #(
    .DW(DW), .NCH(NCH), .TCONV(TCONV), .CFG_RST(CFG_RST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spi(spi.slave),
    .ch_data(ch_data),
    .busy(busy),
    .cfg_word(cfg_word),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < NCH; k++) ch_data[k*DW +: DW] = ch[k];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit running = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h, want %0h",
               nm, cyc, act, exp);
    end
  endtask

  // Expected output timelines, indexed by cycle.
  logic       e_busy [MAXC];
  logic       e_sdo  [MAXC];
  logic       e_done [MAXC];
  logic [5:0] e_cfg  [MAXC];

  task automatic set_busy(input int t, input logic v);
    for (int i = (t < 0 ? 0 : t); i < MAXC; i++) e_busy[i] = v;
  endtask
  task automatic set_sdo(input int t, input logic v);
    for (int i = (t < 0 ? 0 : t); i < MAXC; i++) e_sdo[i] = v;
  endtask
  task automatic set_cfg(input int t, input logic [5:0] v);
    for (int i = (t < 0 ? 0 : t); i < MAXC; i++) e_cfg[i] = v;
  endtask

  // Protocol-level model state.
  logic [5:0]  m_ncfg = CFG_RST;
  logic [5:0]  m_rbits;
  logic [11:0] m_word;
  bit          m_conv, m_frame;
  int          m_end, m_nrise, m_nfall;

  // Raw input change after posedge c takes effect at cycle c+3.
  task automatic model_convst(input int c);
    int t, chn;
    t = c + 3;
    if (m_conv && t < m_end) return;
    chn = m_ncfg[3] * 4 + m_ncfg[2] * 2 + m_ncfg[4];
    m_word  = m_ncfg[0] ? 12'h000 : ch[chn];
    m_conv  = 1'b1;
    m_frame = 1'b1;
    m_end   = t + TCONV;
    m_nrise = 0;
    m_nfall = 0;
    m_rbits = '0;
    set_cfg(t, m_ncfg);
    set_busy(t, 1'b1);
    set_busy(t + TCONV, 1'b0);
    set_sdo(t, 1'b0);
    set_sdo(t + TCONV, m_word[11]);
  endtask

  task automatic model_rise(input int c, input logic v);
    if (!m_frame || c + 3 < m_end || m_nrise >= 6) return;
    m_rbits = {m_rbits[4:0], v};
    m_nrise++;
    if (m_nrise == 6) m_ncfg = m_rbits;
  endtask

  task automatic model_fall(input int c);
    int t;
    t = c + 3;
    if (!m_frame || t < m_end) return;
    m_nfall++;
    if (m_nfall == DW) begin
      set_sdo(t, 1'b0);
      if (t < MAXC) e_done[t] = 1'b1;
      m_frame = 1'b0;
    end else begin
      set_sdo(t, m_word[11 - m_nfall]);
    end
  endtask

  task automatic model_reset(input int c);
    set_busy(c, 1'b0);
    set_sdo(c, 1'b0);
    set_cfg(c, CFG_RST);
    for (int i = c; i < MAXC; i++) e_done[i] = 1'b0;
    m_ncfg  = CFG_RST;
    m_conv  = 1'b0;
    m_frame = 1'b0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (running && cyc < MAXC) begin
      chk("busy", busy, e_busy[cyc]);
      chk("sdo", spi.sdo, e_sdo[cyc]);
      chk("frame_done", frame_done, e_done[cyc]);
      chk("cfg_word", cfg_word, e_cfg[cyc]);
    end
  end

  int done_cnt = 0;
  int rise_c = 0;
  int last_width = 0;
  logic bprev = 1'b0;
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (busy === 1'b1 && !bprev) rise_c = cyc;
    if (busy !== 1'b1 && bprev) last_width = cyc - rise_c;
    bprev = (busy === 1'b1);
  end

  task automatic pulse_convst();
    repeat (6) @(posedge clk);
    #1;
    spi.convst = 1'b1;
    model_convst(cyc);
    repeat (4) @(posedge clk);
    #1;
    spi.convst = 1'b0;
  endtask

  task automatic conv();
    pulse_convst();
    repeat (85) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [5:0] cfg, input int n,
                       input int half, output logic [11:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      spi.sdi = (i < 6) ? cfg[5-i] : 1'b0;
      repeat (half) @(posedge clk);
      #1;
      got = {got[10:0], spi.sdo};
      spi.sck = 1'b1;
      model_rise(cyc, spi.sdi);
      repeat (half) @(posedge clk);
      #1;
      spi.sck = 1'b0;
      model_fall(cyc);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    model_reset(cyc);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [11:0] w;
  int d0;

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 1'b0;
      e_sdo[i]  = 1'b0;
      e_done[i] = 1'b0;
      e_cfg[i]  = CFG_RST;
    end
    for (int k = 0; k < NCH; k++) ch[k] = 12'(12'h111 * k);
    spi.convst = 1'b0;
    spi.sck    = 1'b0;
    spi.sdi    = 1'b0;
    running    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_sdo", spi.sdo, 1'b0);
    chk("rst_cfg", cfg_word, 6'b100010);
    chk("rst_done", frame_done, 1'b0);

    // Basic frame with slow sck
    ch[0] = 12'hA5C;
    conv();
    chk("t1_busy_width", last_width, 80);
    d0 = done_cnt;
    frame(CFG_RST, 12, 81, w);
    chk("t1_word", w, 12'hA5C);
    chk("t1_done_cnt", done_cnt - d0, 1);

    // Config pipelining to channel 1
    ch[1] = 12'h3F0;
    conv();
    frame(6'b110010, 12, 6, w);
    chk("t2_word_a", w, 12'hA5C);
    conv();
    chk("t2_cfg", cfg_word, 6'b110010);
    frame(6'b100011, 12, 6, w);
    chk("t2_word_b", w, 12'h3F0);

    // Sleep returns zero, then wake
    ch[0] = 12'hFFF;
    conv();
    chk("t3_cfg", cfg_word, 6'b100011);
    frame(CFG_RST, 12, 6, w);
    chk("t3_sleep_word", w, 12'h000);
    conv();
    frame(CFG_RST, 12, 6, w);
    chk("t3_wake_word", w, 12'hFFF);

    // Abort after 5 falling edges; short config is dropped
    conv();
    d0 = done_cnt;
    frame(6'b110010, 5, 6, w);
    ch[0] = 12'h5A3;
    conv();
    chk("t4_busy_width", last_width, 80);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_cfg", cfg_word, 6'b100010);
    frame(6'b110010, 12, 6, w);
    chk("t4_word", w, 12'h5A3);

    // Reset during conversion
    ch[0] = 12'hC3A;
    ch[1] = 12'h777;
    pulse_convst();
    repeat (20) @(posedge clk);
    #1;
    chk("t5_busy_pre", busy, 1'b1);
    d0 = done_cnt;
    do_reset(3);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_sdo", spi.sdo, 1'b0);
    chk("t5_cfg", cfg_word, 6'b100010);
    chk("t5_no_done", done_cnt - d0, 0);
    conv();
    frame(CFG_RST, 12, 6, w);
    chk("t5_word", w, 12'hC3A);

    // convst while busy is ignored
    ch[0] = 12'h0F1;
    pulse_convst();
    repeat (30) @(posedge clk);
    pulse_convst();
    repeat (50) @(posedge clk);
    #1;
    chk("t6_busy_width", last_width, 80);
    frame(CFG_RST, 12, 6, w);
    chk("t6_word", w, 12'h0F1);

    if (cyc >= MAXC) begin
      checks++;
      errors++;
      $display("FAIL cycle_budget: got %0d cycles, want < %0d", cyc, MAXC);
    end
    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
